// File: rtl/mem_wb_stage.sv
// MEM-stage data-memory access and MEM/WB pipeline register, with stall/flush,
// a sticky address-range error flag and a saturating committed-store counter.
module mem_wb_stage #(
  parameter int DM_DEPTH = 1024,
  parameter int ADDR_W   = 16,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MEM_VALID,
  input  logic              MEM_DM_WE,
  input  logic              MEM_DM_RE,
  input  logic [31:0]       MEM_ALU_RES,
  input  logic [31:0]       MEM_muxB,
  input  logic [ADDR_W-1:0] MEM_DM_ADDR,
  input  logic              MEM_NEXT_PC,
  input  logic              MEM_RF_D_SEL,
  input  logic              WB_STALL,
  input  logic              WB_FLUSH,
  output logic              WB_VALID,
  output logic [31:0]       WB_ALU_RES,
  output logic [31:0]       WB_DM_RDATA,
  output logic              WB_NEXT_PC,
  output logic              WB_RF_D_SEL,
  output logic [31:0]       WB_RF_DATA,
  output logic              DM_ADDR_ERR,
  output logic [CNT_W-1:0]  STORE_CNT
);

  localparam int IDX_W = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DM_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]      mem [DM_DEPTH];
  logic [IDX_W-1:0] dm_idx;
  logic             acc;
  logic             in_range;
  logic             do_store;
  logic             do_load;
  logic             range_err;
  logic [31:0]      rd_word;

  assign dm_idx    = MEM_DM_ADDR[IDX_W-1:0];
  assign in_range  = {1'b0, MEM_DM_ADDR} < DEPTH_L;
  assign acc       = MEM_VALID & ~WB_STALL & ~WB_FLUSH;
  assign do_store  = rst_n & acc & MEM_DM_WE & in_range;
  assign do_load   = acc & MEM_DM_RE & in_range;
  assign range_err = acc & (MEM_DM_WE | MEM_DM_RE) & ~in_range;

  // Write-first: a combined store+load returns the data being stored.
  assign rd_word = MEM_DM_WE ? MEM_muxB : mem[dm_idx];

  // Memory contents survive reset, so this port has no reset term.
  always_ff @(posedge clk) begin
    if (do_store)
      mem[dm_idx] <= MEM_muxB;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      WB_VALID    <= 1'b0;
      WB_ALU_RES  <= '0;
      WB_DM_RDATA <= '0;
      WB_NEXT_PC  <= 1'b0;
      WB_RF_D_SEL <= 1'b0;
    end else if (WB_STALL) begin
      WB_VALID    <= WB_VALID;
      WB_ALU_RES  <= WB_ALU_RES;
      WB_DM_RDATA <= WB_DM_RDATA;
      WB_NEXT_PC  <= WB_NEXT_PC;
      WB_RF_D_SEL <= WB_RF_D_SEL;
    end else if (WB_FLUSH) begin
      WB_VALID    <= 1'b0;
      WB_ALU_RES  <= '0;
      WB_DM_RDATA <= '0;
      WB_NEXT_PC  <= 1'b0;
      WB_RF_D_SEL <= 1'b0;
    end else begin
      WB_VALID    <= MEM_VALID;
      WB_ALU_RES  <= MEM_ALU_RES;
      WB_DM_RDATA <= do_load ? rd_word : 32'h0;
      WB_NEXT_PC  <= MEM_NEXT_PC;
      WB_RF_D_SEL <= MEM_RF_D_SEL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      DM_ADDR_ERR <= 1'b0;
      STORE_CNT   <= '0;
    end else begin
      if (range_err)
        DM_ADDR_ERR <= 1'b1;
      if (do_store && STORE_CNT != CNT_MAX)
        STORE_CNT <= STORE_CNT + 1'b1;
    end
  end

  assign WB_RF_DATA = WB_RF_D_SEL ? WB_DM_RDATA : WB_ALU_RES;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed-vector bench for mem_wb_stage: each driven cycle queues its
// hand-computed WB state, and a monitor pops and compares after every edge.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        MEM_VALID, MEM_DM_WE, MEM_DM_RE;
  logic [31:0] MEM_ALU_RES, MEM_muxB;
  logic [15:0] MEM_DM_ADDR;
  logic        MEM_NEXT_PC, MEM_RF_D_SEL;
  logic        WB_STALL, WB_FLUSH;
  logic        WB_VALID;
  logic [31:0] WB_ALU_RES, WB_DM_RDATA, WB_RF_DATA;
  logic        WB_NEXT_PC, WB_RF_D_SEL;
  logic        DM_ADDR_ERR;
  logic [3:0]  STORE_CNT;

  mem_wb_stage #(.DM_DEPTH(1024), .ADDR_W(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_VALID(MEM_VALID), .MEM_DM_WE(MEM_DM_WE), .MEM_DM_RE(MEM_DM_RE),
    .MEM_ALU_RES(MEM_ALU_RES), .MEM_muxB(MEM_muxB), .MEM_DM_ADDR(MEM_DM_ADDR),
    .MEM_NEXT_PC(MEM_NEXT_PC), .MEM_RF_D_SEL(MEM_RF_D_SEL),
    .WB_STALL(WB_STALL), .WB_FLUSH(WB_FLUSH),
    .WB_VALID(WB_VALID), .WB_ALU_RES(WB_ALU_RES), .WB_DM_RDATA(WB_DM_RDATA),
    .WB_NEXT_PC(WB_NEXT_PC), .WB_RF_D_SEL(WB_RF_D_SEL), .WB_RF_DATA(WB_RF_DATA),
    .DM_ADDR_ERR(DM_ADDR_ERR), .STORE_CNT(STORE_CNT)
  );

  typedef struct {
    logic        v;
    logic [31:0] alu;
    logic [31:0] rd;
    logic        npc;
    logic        dsel;
    logic [31:0] rf;
    logic        err;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t last;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(logic v, logic [31:0] alu, logic [31:0] rd,
                              logic npc, logic dsel, logic [31:0] rf,
                              logic err, logic [3:0] cnt);
    exp_t e;
    e.v = v; e.alu = alu; e.rd = rd; e.npc = npc; e.dsel = dsel;
    e.rf = rf; e.err = err; e.cnt = cnt;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("WB_VALID",    32'(WB_VALID),    32'(e.v));
    cmp("WB_ALU_RES",  WB_ALU_RES,       e.alu);
    cmp("WB_DM_RDATA", WB_DM_RDATA,      e.rd);
    cmp("WB_NEXT_PC",  32'(WB_NEXT_PC),  32'(e.npc));
    cmp("WB_RF_D_SEL", 32'(WB_RF_D_SEL), 32'(e.dsel));
    cmp("WB_RF_DATA",  WB_RF_DATA,       e.rf);
    cmp("DM_ADDR_ERR", 32'(DM_ADDR_ERR), 32'(e.err));
    cmp("STORE_CNT",   32'(STORE_CNT),   32'(e.cnt));
  endtask

  // Drives one cycle of inputs on the falling edge and queues the WB state
  // expected right after the following rising edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic we,
                               input logic re, input logic [31:0] alu,
                               input logic [31:0] data, input logic [15:0] addr,
                               input logic npc, input logic dsel,
                               input logic stall, input logic flush,
                               input exp_t e);
    @(negedge clk);
    rst_n = rst; MEM_VALID = v; MEM_DM_WE = we; MEM_DM_RE = re;
    MEM_ALU_RES = alu; MEM_muxB = data; MEM_DM_ADDR = addr;
    MEM_NEXT_PC = npc; MEM_RF_D_SEL = dsel; WB_STALL = stall; WB_FLUSH = flush;
    exp_q.push_back(e);
    last = e;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    rst_n = 1'b0; MEM_VALID = 1'b0; MEM_DM_WE = 1'b0; MEM_DM_RE = 1'b0;
    MEM_ALU_RES = '0; MEM_muxB = '0; MEM_DM_ADDR = '0;
    MEM_NEXT_PC = 1'b0; MEM_RF_D_SEL = 1'b0; WB_STALL = 1'b0; WB_FLUSH = 1'b0;

    // Reset and idle
    applyStimulus(0,0,0,0, 32'h0, 32'h0, 16'd0, 0,0, 0,0, mk(0,0,0,0,0,0,0,0));
    applyStimulus(0,0,0,0, 32'h0, 32'h0, 16'd0, 0,0, 0,0, mk(0,0,0,0,0,0,0,0));

    // Seed mem[0], then store/load at address 5
    applyStimulus(1,1,1,0, 32'h100, 32'h11110000, 16'd0, 0,0, 0,0,
                  mk(1,32'h100,0,0,0,32'h100,0,1));
    applyStimulus(1,1,1,0, 32'h14, 32'hDEADBEEF, 16'd5, 1,0, 0,0,
                  mk(1,32'h14,0,1,0,32'h14,0,2));
    applyStimulus(1,1,0,1, 32'h14, 32'h0, 16'd5, 0,1, 0,0,
                  mk(1,32'h14,32'hDEADBEEF,0,1,32'hDEADBEEF,0,2));

    // Combined store+load is write-first
    applyStimulus(1,1,1,1, 32'h1C, 32'h12345678, 16'd7, 0,1, 0,0,
                  mk(1,32'h1C,32'h12345678,0,1,32'h12345678,0,3));
    // Bubble carrying a store: fields load, no side effects
    applyStimulus(1,0,1,1, 32'h55, 32'h99, 16'd9, 1,1, 0,0,
                  mk(0,32'h55,0,1,1,0,0,3));
    applyStimulus(1,1,0,1, 32'h1C, 32'h0, 16'd7, 0,1, 0,0,
                  mk(1,32'h1C,32'h12345678,0,1,32'h12345678,0,3));

    // Three stall cycles with a pending store, then release
    for (int i = 0; i < 3; i++)
      applyStimulus(1,1,1,0, 32'h0C, 32'hA5A5A5A5, 16'd3, 0,0, 1,0, last);
    applyStimulus(1,1,1,0, 32'h0C, 32'hA5A5A5A5, 16'd3, 0,0, 0,0,
                  mk(1,32'h0C,0,0,0,32'h0C,0,4));
    applyStimulus(1,1,0,1, 32'h0C, 32'h0, 16'd3, 0,1, 0,0,
                  mk(1,32'h0C,32'hA5A5A5A5,0,1,32'hA5A5A5A5,0,4));

    // Flush a load and a store; the flushed store must not land
    applyStimulus(1,1,1,0, 32'h10, 32'h40404040, 16'd4, 0,0, 0,0,
                  mk(1,32'h10,0,0,0,32'h10,0,5));
    applyStimulus(1,1,0,1, 32'h0C, 32'h0, 16'd3, 1,1, 0,1, mk(0,0,0,0,0,0,0,5));
    applyStimulus(1,1,1,0, 32'h10, 32'h44444444, 16'd4, 1,1, 0,1, mk(0,0,0,0,0,0,0,5));
    applyStimulus(1,1,0,1, 32'h10, 32'h0, 16'd4, 0,1, 0,0,
                  mk(1,32'h10,32'h40404040,0,1,32'h40404040,0,5));

    // Out-of-range store aliasing to index 0: error set, mem[0] untouched
    applyStimulus(1,1,1,0, 32'h400, 32'hBAD0BAD0, 16'd1024, 0,0, 0,0,
                  mk(1,32'h400,0,0,0,32'h400,1,5));
    applyStimulus(1,1,0,1, 32'h0, 32'h0, 16'd0, 0,1, 0,0,
                  mk(1,0,32'h11110000,0,1,32'h11110000,1,5));
    applyStimulus(1,0,0,0, 32'h0, 32'h0, 16'd0, 0,0, 0,0, mk(0,0,0,0,0,0,1,5));

    // Reset with a store presented: no write, flags cleared
    applyStimulus(0,1,1,0, 32'h0, 32'hFFFFFFFF, 16'd0, 0,0, 0,0, mk(0,0,0,0,0,0,0,0));
    applyStimulus(1,1,0,1, 32'h0, 32'h0, 16'd0, 0,1, 0,0,
                  mk(1,0,32'h11110000,0,1,32'h11110000,0,0));
    // Out-of-range load also flags and returns zero
    applyStimulus(1,1,0,1, 32'h77, 32'h0, 16'hFFFF, 0,1, 0,0,
                  mk(1,32'h77,0,0,1,0,1,0));
    applyStimulus(0,0,0,0, 32'h0, 32'h0, 16'd0, 0,0, 0,0, mk(0,0,0,0,0,0,0,0));

    // 20 stores saturate the 4-bit counter at 15
    for (int i = 0; i < 20; i++)
      applyStimulus(1,1,1,0, 32'h0, 32'h1000 + 32'(i), 16'(10 + i), 0,0, 0,0,
                    mk(1,0,0,0,0,0,0, (i < 15) ? 4'(i + 1) : 4'd15));

    // Reset mid-operation while storing over address 10
    applyStimulus(0,1,1,0, 32'h0, 32'hCAFECAFE, 16'd10, 0,0, 0,0, mk(0,0,0,0,0,0,0,0));
    applyStimulus(1,1,0,1, 32'h0, 32'h0, 16'd10, 0,1, 0,0,
                  mk(1,0,32'h1000,0,1,32'h1000,0,0));
    applyStimulus(1,1,0,1, 32'h0, 32'h0, 16'd29, 0,1, 0,0,
                  mk(1,0,32'h1013,0,1,32'h1013,0,0));
    applyStimulus(1,0,0,0, 32'h0, 32'h0, 16'd0, 0,0, 0,0, mk(0,0,0,0,0,0,0,0));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
